// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared types and round-robin pick function for the request merge
package handshake_pkg;

    localparam int N_REQ_DEF = 3;
    localparam int WIDTH_DEF = 4;
    localparam int SRC_W_DEF = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

    // Upper bound on requester count the pick function can scan.
    localparam int MAX_REQ = 32;

    typedef logic [WIDTH_DEF-1:0] payload_t;
    typedef logic [SRC_W_DEF-1:0] src_t;

    typedef struct packed {
        src_t     src;
        payload_t data;
    } entry_t;

    // First asserted valid at or after ptr, wrapping modulo n; returns ptr when nothing is valid.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int idx;
        int pick;
        pick = ptr;
        // Scan from the far end so the closest candidate to ptr is the one left standing.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[4:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/handshake_fifo.sv
// rtl/handshake_fifo.sv - DEPTH-entry ready/valid FIFO with registered storage and fill count
module handshake_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [W-1:0]             push_data,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    // A full FIFO still takes a beat when the head is leaving in the same cycle.
    assign pop_valid  = (count != '0);
    assign pop        = pop_valid && pop_ready;
    assign push_ready = (count < (AW + 1)'(DEPTH)) || pop;
    assign push       = push_valid && push_ready;
    assign pop_data   = mem[rd_ptr];

    // Storage, pointers and fill count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/handshake_rr_merge.sv
// rtl/handshake_rr_merge.sv - round-robin merge of N_REQ ready/valid requesters into one tagged stream
module handshake_rr_merge
    import handshake_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2,
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [WIDTH-1:0]         req_data [N_REQ-1:0],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic [$clog2(DEPTH):0]   occupancy
);

    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       grant;
    logic                   any_valid;
    logic                   space;
    logic                   accept;
    logic [MAX_REQ-1:0]     valid_ext;
    logic [SRC_W+WIDTH-1:0] push_data;
    logic [SRC_W+WIDTH-1:0] pop_data;

    assign valid_ext = MAX_REQ'(req_valid);
    assign any_valid = |req_valid;
    assign accept    = any_valid && space && ASYNCRESETN;
    assign push_data = {grant, req_data[grant]};
    assign {out_src, out_data} = pop_data;

    // Grant the first valid requester at or after rr_ptr; only the winner sees ready, and never during reset.
    always_comb begin
        grant     = SRC_W'(rr_pick(valid_ext, int'(rr_ptr), N_REQ));
        req_ready = '0;
        if (ASYNCRESETN && any_valid) begin
            req_ready[grant] = space;
        end
    end

    // Move the round-robin pointer just past the winner on each accepted beat.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant == SRC_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    handshake_fifo #(
        .W     (SRC_W + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .push_valid  (accept),
        .push_ready  (space),
        .push_data   (push_data),
        .pop_valid   (out_valid),
        .pop_ready   (out_ready),
        .pop_data    (pop_data),
        .count       (occupancy)
    );

endmodule

// File: tb/tb_handshake_rr_merge.sv
// tb/tb_handshake_rr_merge.sv - directed self-checking bench for handshake_rr_merge
module tb_handshake_rr_merge;

    logic       CLK;
    logic       ASYNCRESETN;
    logic [2:0] req_valid;
    logic [2:0] req_ready;
    logic [3:0] req_data [2:0];
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic [1:0] occupancy;

    int n_checks;
    int n_fail;
    int g0_cnt;
    int g2_cnt;

    handshake_rr_merge #(
        .N_REQ (3),
        .WIDTH (4),
        .DEPTH (2)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src     (out_src),
        .occupancy   (occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESETN = 1'b0;
        req_valid   = 3'b000;
        out_ready   = 1'b0;
        repeat (2) @(negedge CLK);
        ASYNCRESETN = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        g0_cnt      = 0;
        g2_cnt      = 0;
        ASYNCRESETN = 1'b0;
        out_ready   = 1'b1;
        req_valid   = 3'b010;
        req_data[0] = 4'h0;
        req_data[1] = 4'hA;
        req_data[2] = 4'h0;

        // Reset state, with a requester already asking
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_src",   32'(out_src),   32'h0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;

        // 1: single beat
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'h2);
        chk("t1_c0_out_valid", 32'(out_valid), 32'h0);
        tick();
        req_valid = 3'b000;
        chk("t1_out_valid", 32'(out_valid), 32'h1);
        chk("t1_out_data",  32'(out_data),  32'hA);
        chk("t1_out_src",   32'(out_src),   32'h1);
        chk("t1_occ1",      32'(occupancy), 32'h1);
        tick();
        chk("t1_drained_valid", 32'(out_valid), 32'h0);
        chk("t1_drained_occ",   32'(occupancy), 32'h0);

        // 2: full contention from a fresh reset
        do_reset();
        out_ready   = 1'b1;
        req_data[0] = 4'h1;
        req_data[1] = 4'h2;
        req_data[2] = 4'h3;
        req_valid   = 3'b111;
        #1;
        chk("t2_first_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_out_valid", 32'(out_valid), 32'h1);
            chk("t2_out_src",   32'(out_src),   32'(i % 3));
            chk("t2_out_data",  32'(out_data),  32'(i % 3 + 1));
        end
        req_valid = 3'b000;
        tick();
        chk("t2_drained_occ", 32'(occupancy), 32'h0);

        // 3: backpressure fills the FIFO, then drain in order
        out_ready   = 1'b0;
        req_valid   = 3'b001;
        req_data[0] = 4'h5;
        #1;
        chk("t3_ready_5", 32'(req_ready), 32'h1);
        tick();
        req_data[0] = 4'h6;
        chk("t3_ready_6", 32'(req_ready), 32'h1);
        tick();
        req_data[0] = 4'h7;
        chk("t3_ready_7_blocked", 32'(req_ready), 32'h0);
        chk("t3_occ_full",        32'(occupancy), 32'h2);
        chk("t3_head_5",          32'(out_data),  32'h5);
        tick();
        chk("t3_hold_data", 32'(out_data),  32'h5);
        chk("t3_hold_occ",  32'(occupancy), 32'h2);
        chk("t3_hold_rdy",  32'(req_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        chk("t3_ready_7_open", 32'(req_ready), 32'h1);
        tick();
        req_valid = 3'b000;
        chk("t3_out_6",   32'(out_data),  32'h6);
        chk("t3_occ_6",   32'(occupancy), 32'h2);
        tick();
        chk("t3_out_7",   32'(out_data),  32'h7);
        chk("t3_occ_7",   32'(occupancy), 32'h1);
        tick();
        chk("t3_empty",   32'(out_valid), 32'h0);

        // 4: push and pop together while full
        out_ready   = 1'b0;
        req_valid   = 3'b001;
        req_data[0] = 4'h8;
        tick();
        req_data[0] = 4'h9;
        tick();
        chk("t4_full", 32'(occupancy), 32'h2);
        out_ready   = 1'b1;
        req_valid   = 3'b100;
        req_data[2] = 4'hF;
        #1;
        chk("t4_ready_2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 3'b000;
        chk("t4_occ_stays", 32'(occupancy), 32'h2);
        chk("t4_out_9",     32'(out_data),  32'h9);
        tick();
        chk("t4_out_F",     32'(out_data),  32'hF);
        chk("t4_src_2",     32'(out_src),   32'h2);
        tick();
        chk("t4_empty",     32'(occupancy), 32'h0);

        // 5: asynchronous reset with beats pending
        out_ready   = 1'b0;
        req_valid   = 3'b010;
        req_data[1] = 4'h4;
        tick();
        tick();
        req_valid = 3'b000;
        chk("t5_full", 32'(occupancy), 32'h2);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'h0);
        chk("t5_async_occ",   32'(occupancy), 32'h0);
        req_valid   = 3'b111;
        out_ready   = 1'b1;
        req_data[0] = 4'h1;
        req_data[1] = 4'h4;
        req_data[2] = 4'hF;
        #1;
        chk("t5_ready_in_rst", 32'(req_ready), 32'h0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        #1;
        chk("t5_ready_after", 32'(req_ready), 32'h1);
        tick();
        req_valid = 3'b000;
        chk("t5_out_src",  32'(out_src),  32'h0);
        chk("t5_out_data", 32'(out_data), 32'h1);
        tick();
        chk("t5_drained", 32'(occupancy), 32'h0);

        // 6: sparse fairness, rr_ptr starts at 1 after the grant above
        for (int k = 0; k < 6; k++) begin
            req_valid   = (k % 2 == 0) ? 3'b100 : 3'b101;
            req_data[0] = 4'(k);
            req_data[2] = 4'(k + 8);
            #1;
            chk("t6_req_ready", 32'(req_ready), (k % 2 == 0) ? 32'h4 : 32'h1);
            tick();
            chk("t6_out_src",  32'(out_src),  (k % 2 == 0) ? 32'h2 : 32'h0);
            chk("t6_out_data", 32'(out_data), (k % 2 == 0) ? 32'(k + 8) : 32'(k));
            if (out_valid && out_src == 2'd0) g0_cnt++;
            if (out_valid && out_src == 2'd2) g2_cnt++;
        end
        req_valid = 3'b000;
        tick();
        chk("t6_g0_count", 32'(g0_cnt), 32'd3);
        chk("t6_g2_count", 32'(g2_cnt), 32'd3);
        chk("t6_drained",  32'(occupancy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_rr_merge.md
Name: handshake_rr_merge

Overview:
- Upstream neighbour of foo_RTL.
- Merges N_REQ independent ready/valid requesters into the single ready/valid + 4-bit data stream that foo_RTL consumes on handshake_valid/handshake_ready/in1.
- Round-robin arbitration feeds a small registered output FIFO. foo_RTL therefore sees registered, stable handshake outputs.
- out_src tags each beat with its originating requester for downstream checking.

Parameters:
N_REQ, 3, number of upstream requesters (>=2)
WIDTH, 4, payload width in bits
DEPTH, 2, output FIFO entries (>=2, power of two)
SRC_W, max(1,$clog2(N_REQ)), width of source tag (derived, not overridable)

Ports:
CLK  input  1  clock, rising edge
ASYNCRESETN  input  1  reset, asynchronous assert, active-low
req_valid  input  N_REQ  per-requester valid
req_ready  output  N_REQ  per-requester ready (one-hot or zero)
req_data  input  N_REQ x WIDTH  per-requester payload, unpacked array [N_REQ-1:0]
out_valid  output  1  merged stream valid
out_ready  input  1  merged stream ready from consumer
out_data  output  WIDTH  merged payload
out_src  output  SRC_W  index of requester that produced out_data
occupancy  output  $clog2(DEPTH)+1  current FIFO fill count

Behaviour:
- Reset (ASYNCRESETN=0, asynchronous):
  - FIFO count=0; rd/wr pointers=0; rr_ptr=0.
  - All storage entries = 0.
  - out_valid=0, out_data=0, out_src=0, occupancy=0.
  - req_ready is forced to 0 while reset is asserted.
  - Reset mid-operation discards all buffered beats. Held-off requesters are re-arbitrated from index 0 after release.
- Space term: space = (count<DEPTH) || (out_valid && out_ready). Push and pop in the same cycle is legal when full.
- Arbitration (combinational):
  - grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[g] = space. All other req_ready bits = 0.
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
- Accept: accept = req_valid[g] && req_ready[g].
  - On accept, {g, req_data[g]} is written at wr_ptr.
  - rr_ptr <= (g+1) mod N_REQ.
  - With no accept, rr_ptr holds.
- Output: out_valid = (count!=0); out_data/out_src = entry at rd_ptr.
  - Output fire = out_valid && out_ready advances rd_ptr.
  - While out_valid && !out_ready, out_data and out_src are held stable; the bound monitor asserts this.
- Latency: a beat accepted in cycle t appears on out_valid in cycle t+1 at the earliest (FIFO empty case). Throughput is 1 beat/cycle sustained.
- Count update:
  - +1 on accept only.
  - -1 on fire only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH; never underflows.
- Pointer wrap: rd/wr pointers wrap modulo DEPTH.
- Fairness: under continuous contention, each requester is granted at least once every N_REQ accepts.
- Ordering: beats from one requester exit in acceptance order. No beat is dropped or duplicated.
- Idle: with all req_valid=0, no state changes except FIFO drain.

Decomposition:
- Package handshake_pkg:
  - localparams N_REQ_DEF=3, WIDTH_DEF=4.
  - typedef payload_t = logic [WIDTH-1:0].
  - typedef src_t = logic [SRC_W-1:0].
  - packed struct entry_t {src_t src; payload_t data;}.
  - function rr_pick(valid, ptr) returning the grant index.
- Sub-module handshake_fifo:
  - Generic DEPTH-entry ready/valid FIFO over entry_t, same CLK/ASYNCRESETN.
  - Exposes push_valid/push_ready/push_data, pop_valid/pop_ready/pop_data, count.
- The top level holds the arbiter, rr_ptr register and the fifo instance.

Test Plan:
1. Reset release, single beat: req_valid=3'b010, req_data[1]=4'hA, out_ready=1 → req_ready=3'b010 in cycle 0; cycle 1 out_valid=1, out_data=4'hA, out_src=1; cycle 2 out_valid=0, occupancy=0.
2. Full contention, round-robin: all req_valid=1 with data {2:4'h3, 1:4'h2, 0:4'h1}, out_ready=1 → out_src sequence 0,1,2,0,1,2; out_data 1,2,3,1,2,3; one beat per cycle.
3. Backpressure and fill: out_ready=0, req_valid=3'b001 with data 5,6,7 on successive cycles → 5 and 6 accepted; occupancy=2; req_ready[0]=0 while 7 waits; out_data stays 5. Then out_ready=1 → outputs 5,6,7 in order.
4. Simultaneous push/pop at full: occupancy=2, out_ready=1, req_valid[2]=1, data=4'hF → req_ready[2]=1; occupancy stays 2; 4'hF exits two fires later.
5. Mid-operation reset: occupancy=2 with beats pending, pulse ASYNCRESETN low between clock edges → out_valid and occupancy drop to 0 immediately (asynchronously); after release, first grant with all valid goes to requester 0.
6. Sparse fairness: req_valid alternates 3'b100 and 3'b101 each cycle → across 6 accepts, requester 0 granted ≥2 and requester 2 granted ≥3; no beat lost (scoreboard by out_src).
